// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine
//   Computes c = m^e mod p using left-to-right square-and-multiply. Each modular
//   product comes from a bit-serial interleaved multiplier, which needs no
//   Montgomery precomputation.
//
//   Square steps and multiply steps always both run, so the job time does not
//   depend on the value of the exponent.
//
// Parameters
//   WIDTH      bit width of p, m and c
//   EXP_WIDTH  bit width of e; the exponent bits are consumed MSB first
//
// Ports
//   clk, rst   system clock; synchronous active-high reset
//   ena        clock enable; while low, every register holds its value
//   start      starts a job when the block is idle
//   stop       aborts a running job; in IDLE it blocks start
//   irq_en     interrupt mask
//   irq_clr    clears the sticky interrupt-pending flag
//   p, e, m    operands, captured in LOAD
//   busy       high in LOAD, SQR and MUL
//   done       one-cycle completion pulse, for success and for error
//   err        1 when the last job had invalid operands (p < 2 or m >= p)
//   c          result register
//   irq        irq_pend AND irq_en
module rsa_modexp_engine #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 irq_en,
  input  logic                 irq_clr,
  input  logic [WIDTH-1:0]     p,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [WIDTH-1:0]     m,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     c,
  output logic                 irq
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int J_W   = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [J_W-1:0]   J_MSB    = J_W'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQR,
    MUL,
    FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]     p_reg;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [WIDTH-1:0]     m_reg;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     mm_r;
  logic [CNT_W-1:0]     mm_cnt;
  logic [J_W-1:0]       j_idx;
  logic                 irq_pend;

  logic                 invalid;
  logic                 mm_last;
  logic                 j_last;
  logic                 y_bit;
  logic [WIDTH:0]       p_ext;
  logic [WIDTH:0]       t_dbl_raw;
  logic [WIDTH:0]       t_dbl;
  logic [WIDTH:0]       t_sum;
  logic [WIDTH:0]       t_add;
  logic [WIDTH-1:0]     step_r;
  logic [WIDTH-1:0]     acc_after_mul;

  // Operands are validated while LOAD is active. The inputs are checked
  // directly here because the capture registers load on the same edge.
  assign invalid = (p[WIDTH-1:1] == '0) || (m >= p);

  assign mm_last = (mm_cnt == '0);
  assign j_last  = (j_idx == '0);
  assign p_ext   = {1'b0, p_reg};

  // One step of the interleaved multiplier, x = acc and y = acc or m_reg.
  // acc is only written on the final step of a product, so it can serve as the
  // multiplicand for the whole product. Each intermediate value is below
  // 2*p_reg, so one spare bit is enough and one conditional subtraction
  // reduces it.
  always_comb begin
    t_dbl_raw = {mm_r, 1'b0};
    t_dbl     = t_dbl_raw;
    if (t_dbl_raw >= p_ext) begin
      t_dbl = t_dbl_raw - p_ext;
    end
    y_bit = (state == SQR) ? acc[mm_cnt] : m_reg[mm_cnt];
    t_sum = t_dbl + {1'b0, acc};
    t_add = t_dbl;
    if (y_bit) begin
      t_add = t_sum;
      if (t_sum >= p_ext) begin
        t_add = t_sum - p_ext;
      end
    end
    step_r = t_add[WIDTH-1:0];
  end

  // The multiply pass runs for every exponent bit so that timing stays
  // constant. Its product is kept only when the current exponent bit is set.
  assign acc_after_mul = e_reg[j_idx] ? step_r : acc;

  // State register. It advances only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // Next-state logic. stop takes priority over every other transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!stop && start) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (invalid) begin
          state_nxt = FIN;
        end else begin
          state_nxt = SQR;
        end
      end
      SQR: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (mm_last) begin
          state_nxt = MUL;
        end
      end
      MUL: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (mm_last) begin
          state_nxt = j_last ? FIN : SQR;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers: operand capture, accumulator, multiplier step state,
  // exponent index, result, error flag and sticky interrupt.
  // An aborted job leaves c and err untouched, so every update is gated by
  // !stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg    <= '0;
      e_reg    <= '0;
      m_reg    <= '0;
      acc      <= '0;
      mm_r     <= '0;
      mm_cnt   <= '0;
      j_idx    <= '0;
      c        <= '0;
      err      <= 1'b0;
      irq_pend <= 1'b0;
    end else if (ena) begin
      // A done in the same cycle as irq_clr must still leave irq_pend set.
      if (irq_clr) begin
        irq_pend <= 1'b0;
      end
      if (state == FIN) begin
        irq_pend <= 1'b1;
      end

      unique case (state)
        LOAD: begin
          if (!stop) begin
            p_reg <= p;
            e_reg <= e;
            m_reg <= m;
            if (invalid) begin
              err <= 1'b1;
              c   <= '0;
            end else begin
              err    <= 1'b0;
              acc    <= WIDTH'(1);
              j_idx  <= J_MSB;
              mm_r   <= '0;
              mm_cnt <= CNT_LAST;
            end
          end
        end
        SQR: begin
          if (!stop) begin
            if (mm_last) begin
              acc    <= step_r;
              mm_r   <= '0;
              mm_cnt <= CNT_LAST;
            end else begin
              mm_r   <= step_r;
              mm_cnt <= mm_cnt - CNT_W'(1);
            end
          end
        end
        MUL: begin
          if (!stop) begin
            if (mm_last) begin
              acc    <= acc_after_mul;
              mm_r   <= '0;
              mm_cnt <= CNT_LAST;
              if (j_last) begin
                c <= acc_after_mul;
              end else begin
                j_idx <= j_idx - J_W'(1);
              end
            end else begin
              mm_r   <= step_r;
              mm_cnt <= mm_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs come straight from the state. done is masked by ena, so a
  // frozen FIN cycle produces only one pulse.
  assign busy = (state == LOAD) || (state == SQR) || (state == MUL);
  assign done = (state == FIN) && ena;
  assign irq  = irq_pend && irq_en;

endmodule
